// File: rtl/rfid_pkg.sv
// Shared constants and types for the RFID uplink/downlink blocks.
// Packet geometry and the FM0 preamble are common to rfid_transmit and rfid_receive.
package rfid_pkg;

    localparam int DATA_W       = 128;
    localparam int LEN_W        = 8;
    localparam int PREAMBLE_LEN = 12;
    localparam int PRE_IDX_W    = $clog2(PREAMBLE_LEN);

    // Half-symbol levels, MSB first; contains the deliberate FM0 violation.
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE   = 12'b110100100011;
    localparam logic                    IDLE_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_DUMMY    = 3'd3,
        ST_DONE     = 3'd4
    } tx_state_e;

    // Lengths beyond the packet register send the whole register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] max_len;
        max_len = LEN_W'(DATA_W);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/fm0_encoder.sv
// FM0 level generator: holds the line level and derives the next half-symbol.
// Clear has priority over a direct load, which has priority over an FM0 advance.
module fm0_encoder
    import rfid_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_load_level,
    input  logic i_adv,
    input  logic i_second_half,
    input  logic i_bit,
    output logic o_level
);

    logic r_level;
    logic w_level_next;

    // Next level: first half always toggles, second half holds only for a data-1.
    always_comb begin
        w_level_next = r_level;
        if (i_clear) begin
            w_level_next = IDLE_LEVEL;
        end else if (i_load) begin
            w_level_next = i_load_level;
        end else if (i_adv) begin
            if (i_second_half && i_bit) begin
                w_level_next = r_level;
            end else begin
                w_level_next = ~r_level;
            end
        end else begin
            w_level_next = r_level;
        end
    end

    // Level register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= IDLE_LEVEL;
        end else begin
            r_level <= w_level_next;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/rfid_transmit.sv
// Uplink transmitter: serialises a left-aligned packet as FM0 with preamble and dummy-1.
// State names describe the half-symbol currently on UL_data; r_half marks which half.
module rfid_transmit
    import rfid_pkg::*;
(
    input  logic              UL_clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] packet_in,
    input  logic [LEN_W-1:0]  packet_len,
    input  logic              packet_valid,
    output logic              packet_ready,
    output logic              UL_data,
    output logic              tx_busy,
    output logic              tx_done
);

    tx_state_e            r_state, w_state_next;
    logic [DATA_W-1:0]    r_shift, w_shift_next;
    logic [LEN_W-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic [PRE_IDX_W-1:0] r_pre_idx, w_pre_idx_next;
    logic                 r_half, w_half_next;
    logic                 r_ready, r_busy, r_done;
    logic                 w_accept;
    logic                 w_enc_clear, w_enc_load, w_enc_load_level;
    logic                 w_enc_adv, w_enc_second, w_enc_bit;
    logic                 w_level;

    assign w_accept = packet_valid && r_ready;

    // Next-state and encoder control, one step per half-symbol.
    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_bit_cnt_next   = r_bit_cnt;
        w_pre_idx_next   = r_pre_idx;
        w_half_next      = r_half;
        w_enc_clear      = 1'b0;
        w_enc_load       = 1'b0;
        w_enc_load_level = 1'b0;
        w_enc_adv        = 1'b0;
        w_enc_second     = 1'b0;
        w_enc_bit        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_enc_load       = 1'b1;
                    w_enc_load_level = PREAMBLE[PREAMBLE_LEN-1];
                    w_shift_next     = packet_in;
                    w_bit_cnt_next   = clamp_len(packet_len);
                    w_pre_idx_next   = PRE_IDX_W'(PREAMBLE_LEN - 1);
                    w_half_next      = 1'b0;
                    w_state_next     = ST_PREAMBLE;
                end else begin
                    w_enc_clear = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (r_pre_idx != PRE_IDX_W'(0)) begin
                    w_enc_load       = 1'b1;
                    w_enc_load_level = PREAMBLE[r_pre_idx - PRE_IDX_W'(1)];
                    w_pre_idx_next   = r_pre_idx - PRE_IDX_W'(1);
                end else begin
                    w_enc_adv    = 1'b1;
                    w_half_next  = 1'b0;
                    w_state_next = (r_bit_cnt != LEN_W'(0)) ? ST_DATA : ST_DUMMY;
                end
            end
            ST_DATA: begin
                w_enc_adv = 1'b1;
                if (!r_half) begin
                    w_enc_second = 1'b1;
                    w_enc_bit    = r_shift[DATA_W-1];
                    w_half_next  = 1'b1;
                end else begin
                    // Bit finished: move to the next bit's first half.
                    w_shift_next   = {r_shift[DATA_W-2:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt - LEN_W'(1);
                    w_half_next    = 1'b0;
                    w_state_next   = (r_bit_cnt == LEN_W'(1)) ? ST_DUMMY : ST_DATA;
                end
            end
            ST_DUMMY: begin
                if (!r_half) begin
                    w_enc_adv    = 1'b1;
                    w_enc_second = 1'b1;
                    w_enc_bit    = 1'b1;
                    w_half_next  = 1'b1;
                end else begin
                    w_enc_clear  = 1'b1;
                    w_half_next  = 1'b0;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_enc_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_enc_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge UL_clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pre_idx <= '0;
            r_half    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_pre_idx <= w_pre_idx_next;
            r_half    <= w_half_next;
            r_ready   <= (w_state_next == ST_IDLE);
            r_busy    <= (w_state_next == ST_PREAMBLE) || (w_state_next == ST_DATA) ||
                         (w_state_next == ST_DUMMY);
            r_done    <= (w_state_next == ST_DONE);
        end
    end

    fm0_encoder u_fm0 (
        .i_clk         (UL_clock),
        .i_rst         (reset),
        .i_clear       (w_enc_clear),
        .i_load        (w_enc_load),
        .i_load_level  (w_enc_load_level),
        .i_adv         (w_enc_adv),
        .i_second_half (w_enc_second),
        .i_bit         (w_enc_bit),
        .o_level       (w_level)
    );

    assign UL_data      = w_level;
    assign packet_ready = r_ready;
    assign tx_busy      = r_busy;
    assign tx_done      = r_done;

endmodule

// File: tb/tb_rfid_transmit.sv
// Self-checking bench for rfid_transmit: directed FM0 waveforms plus randomized
// packets checked against a half-symbol list model and an FM0 decoder.
module tb_rfid_transmit;

    logic         UL_clock;
    logic         reset;
    logic [127:0] packet_in;
    logic [7:0]   packet_len;
    logic         packet_valid;
    logic         packet_ready;
    logic         UL_data;
    logic         tx_busy;
    logic         tx_done;

    int compared   = 0;
    int mismatched = 0;
    int busy_cnt;
    int done_cnt;
    bit exp_q[$];
    bit got_q[$];

    localparam logic [11:0] PRE_BITS = 12'b110100100011;

    rfid_transmit dut (
        .UL_clock     (UL_clock),
        .reset        (reset),
        .packet_in    (packet_in),
        .packet_len   (packet_len),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .UL_data      (UL_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    initial UL_clock = 1'b0;
    always #5 UL_clock = ~UL_clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: list of expected half-symbol levels for one packet.
    task automatic build_expected(input logic [127:0] pkt, input logic [7:0] len);
        int         n;
        bit         lvl;
        bit         b;
        logic [11:0] pre_v;
        pre_v = PRE_BITS;
        exp_q.delete();
        n = (int'(len) > 128) ? 128 : int'(len);
        for (int i = 11; i >= 0; i--) exp_q.push_back(pre_v[i]);
        lvl = exp_q[exp_q.size()-1];
        for (int i = 0; i <= n; i++) begin
            b = (i == n) ? 1'b1 : pkt[127-i];
            lvl = !lvl;
            exp_q.push_back(lvl);
            if (!b) lvl = !lvl;
            exp_q.push_back(lvl);
        end
    endtask

    function automatic logic [127:0] rand_pkt();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Sends one packet and checks every half-symbol and the status flags.
    task automatic send_pkt(input logic [127:0] pkt, input logic [7:0] len, input bit noise);
        int nexp;
        int waitc;
        build_expected(pkt, len);
        nexp = exp_q.size();
        got_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        waitc    = 0;
        while (packet_ready !== 1'b1 && waitc < 400) begin
            @(negedge UL_clock);
            waitc++;
        end
        compared++;
        if (packet_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_before_send: got %b want 1", packet_ready);
        end
        packet_in    = pkt;
        packet_len   = len;
        packet_valid = 1'b1;
        @(negedge UL_clock);
        for (int i = 0; i < nexp; i++) begin
            got_q.push_back(UL_data);
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) done_cnt++;
            compared++;
            if (UL_data !== exp_q[i]) begin
                mismatched++;
                $display("FAIL ul_data[%0d] len=%0d: got %b want %b", i, len, UL_data, exp_q[i]);
            end
            compared++;
            if ({tx_busy, packet_ready, tx_done} !== 3'b100) begin
                mismatched++;
                $display("FAIL busy_flags[%0d]: got busy/ready/done=%b want 100", i,
                         {tx_busy, packet_ready, tx_done});
            end
            packet_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            packet_in    = rand_pkt();
            packet_len   = 8'($urandom_range(0, 255));
            @(negedge UL_clock);
        end
        packet_valid = 1'b0;
        if (tx_busy === 1'b1) busy_cnt++;
        if (tx_done === 1'b1) done_cnt++;
        compared++;
        if ({UL_data, tx_busy, packet_ready, tx_done} !== 4'b0001) begin
            mismatched++;
            $display("FAIL done_cycle: got data/busy/ready/done=%b want 0001",
                     {UL_data, tx_busy, packet_ready, tx_done});
        end
        @(negedge UL_clock);
        if (tx_done === 1'b1) done_cnt++;
        compared++;
        if ({UL_data, tx_busy, packet_ready, tx_done} !== 4'b0010) begin
            mismatched++;
            $display("FAIL idle_after_done: got data/busy/ready/done=%b want 0010",
                     {UL_data, tx_busy, packet_ready, tx_done});
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        packet_valid = 1'b0;
        packet_in    = '0;
        packet_len   = 8'd0;
        repeat (3) @(negedge UL_clock);
        compared++;
        if ({UL_data, tx_busy, packet_ready, tx_done} !== 4'b0010) begin
            mismatched++;
            $display("FAIL reset_state: got data/busy/ready/done=%b want 0010",
                     {UL_data, tx_busy, packet_ready, tx_done});
        end
        reset = 1'b0;
        @(negedge UL_clock);
        compared++;
        if ({UL_data, tx_busy, packet_ready, tx_done} !== 4'b0010) begin
            mismatched++;
            $display("FAIL after_reset_release: got %b want 0010",
                     {UL_data, tx_busy, packet_ready, tx_done});
        end
    endtask

    task automatic test_len1();
        logic [127:0] pkt;
        logic [15:0]  want;
        logic [15:0]  got_v;
        pkt      = rand_pkt();
        pkt[127] = 1'b0;
        want     = 16'b110100100011_01_00;
        send_pkt(pkt, 8'd1, 1'b0);
        for (int i = 0; i < 16; i++) got_v[15-i] = got_q[i];
        compared++;
        if (got_v !== want) begin
            mismatched++;
            $display("FAIL len1_wave: got %b want %b", got_v, want);
        end
        compared++;
        if (done_cnt !== 1) begin
            mismatched++;
            $display("FAIL len1_done_pulses: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_len4();
        logic [127:0] pkt;
        logic [21:0]  want;
        logic [21:0]  got_v;
        pkt          = rand_pkt();
        pkt[127:124] = 4'b1100;
        want         = 22'b110100100011_00110101_00;
        send_pkt(pkt, 8'd4, 1'b0);
        for (int i = 0; i < 22; i++) got_v[21-i] = got_q[i];
        compared++;
        if (got_v !== want) begin
            mismatched++;
            $display("FAIL len4_wave: got %b want %b", got_v, want);
        end
        compared++;
        if (busy_cnt !== 22) begin
            mismatched++;
            $display("FAIL len4_busy_cycles: got %0d want 22", busy_cnt);
        end
    endtask

    task automatic test_len0();
        logic [13:0] want;
        logic [13:0] got_v;
        want = 14'b110100100011_00;
        send_pkt(rand_pkt(), 8'd0, 1'b0);
        for (int i = 0; i < 14; i++) got_v[13-i] = got_q[i];
        compared++;
        if (got_v !== want) begin
            mismatched++;
            $display("FAIL len0_wave: got %b want %b", got_v, want);
        end
        compared++;
        if (busy_cnt !== 14 || done_cnt !== 1) begin
            mismatched++;
            $display("FAIL len0_busy_done: got busy=%0d done=%0d want 14 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_clamp();
        logic [127:0] pkt;
        int           errs;
        bit           h1, h2, prev;
        pkt  = {4{32'hAAAA_AAAA}};
        errs = 0;
        send_pkt(pkt, 8'd200, 1'b0);
        compared++;
        if (busy_cnt !== 270) begin
            mismatched++;
            $display("FAIL clamp_busy_cycles: got %0d want 270", busy_cnt);
        end
        for (int k = 0; k <= 128; k++) begin
            prev = got_q[11+2*k];
            h1   = got_q[12+2*k];
            h2   = got_q[13+2*k];
            if (h1 == prev) errs++;
            if ((h1 == h2) != ((k == 128) ? 1'b1 : pkt[127-k])) errs++;
        end
        compared++;
        if (errs !== 0) begin
            mismatched++;
            $display("FAIL clamp_fm0_decode: got %0d symbol errors want 0", errs);
        end
    endtask

    task automatic test_random();
        logic [7:0] len;
        int         n;
        for (int t = 0; t < 8; t++) begin
            len = 8'($urandom_range(0, 140));
            n   = (int'(len) > 128) ? 128 : int'(len);
            send_pkt(rand_pkt(), len, 1'b0);
            compared++;
            if (busy_cnt !== 12 + 2*n + 2 || done_cnt !== 1) begin
                mismatched++;
                $display("FAIL random_busy_done[%0d]: got busy=%0d done=%0d want %0d 1",
                         t, busy_cnt, done_cnt, 12 + 2*n + 2);
            end
        end
    endtask

    task automatic test_ignore_valid();
        send_pkt(rand_pkt(), 8'd10, 1'b1);
        compared++;
        if (busy_cnt !== 34 || done_cnt !== 1) begin
            mismatched++;
            $display("FAIL noise_busy_done: got busy=%0d done=%0d want 34 1", busy_cnt, done_cnt);
        end
        send_pkt(rand_pkt(), 8'd3, 1'b0);
        compared++;
        if (busy_cnt !== 20) begin
            mismatched++;
            $display("FAIL after_noise_busy: got %0d want 20", busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pkt;
        pkt          = rand_pkt();
        pkt[127:120] = 8'b0110_1010;
        build_expected(pkt, 8'd8);
        packet_in    = pkt;
        packet_len   = 8'd8;
        packet_valid = 1'b1;
        @(negedge UL_clock);
        packet_valid = 1'b0;
        repeat (16) @(negedge UL_clock);
        compared++;
        if (UL_data !== exp_q[16] || tx_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_level: got data=%b busy=%b want %b 1", UL_data, tx_busy, exp_q[16]);
        end
        #1;
        reset = 1'b1;
        #1;
        compared++;
        if ({UL_data, tx_busy, packet_ready, tx_done} !== 4'b0010) begin
            mismatched++;
            $display("FAIL async_reset: got data/busy/ready/done=%b want 0010",
                     {UL_data, tx_busy, packet_ready, tx_done});
        end
        repeat (2) @(negedge UL_clock);
        reset = 1'b0;
        @(negedge UL_clock);
        send_pkt(rand_pkt() & {1'b0, {127{1'b1}}}, 8'd1, 1'b0);
        compared++;
        if (busy_cnt !== 16) begin
            mismatched++;
            $display("FAIL post_reset_busy: got %0d want 16", busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_len1();
        test_len4();
        test_len0();
        test_random();
        test_clamp();
        test_ignore_valid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
